// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Central sequencer for the 5-stage pipeline. It merges the load-use stall,
//   the EX mispredict redirect and the data-memory ready handshake into one
//   consistent set of PC and stage-register enables, flushes and bubbles. It
//   also runs the ECALL halt drain and keeps stall and flush counters.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   hz_stall        load-use stall request for the ID instruction
//   ex_mispredict   EX branch/jump mispredict, redirect PC this cycle
//   id_halt_req     ID instruction is a halting ECALL
//   mem_req         MEM stage holds a load or store
//   mem_ready       data memory completes the access this cycle
//   pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
//   ex_mem_write, mem_wb_bubble      stage controls (combinational)
//   is_halted       pipeline drained after halt
//   stall_count     cycles with pc_write == 0 in RUN/DRAIN (saturating)
//   flush_count     accepted mispredicts (saturating)
module pipeline_stall_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hz_stall,
  input  logic             ex_mispredict,
  input  logic             id_halt_req,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             is_halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DC_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DC_W-1:0] DRAIN_INIT = DC_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t            state_q, state_d;
  logic [DC_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              mem_freeze;
  logic              flush_inc;
  logic              stall_inc;

  assign mem_freeze = mem_req && !mem_ready;

  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b0;
    mem_wb_bubble = 1'b0;
    is_halted     = 1'b0;
    flush_inc     = 1'b0;
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;

    if (!reset) begin
      unique case (state_q)
        S_RUN: begin
          if (mem_freeze) begin
            // Whole pipe holds; requesters keep mispredict/halt asserted.
            mem_wb_bubble = 1'b1;
          end else if (ex_mispredict) begin
            // ID holds a wrong-path instruction, so stall/halt are moot.
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_write = 1'b1;
            flush_inc    = 1'b1;
          end else if (hz_stall) begin
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_write = 1'b1;
          end else if (id_halt_req) begin
            // Stop fetch; ECALL itself advances out of ID.
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            state_d      = S_DRAIN;
            drain_cnt_d  = DRAIN_INIT;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
          end
        end
        S_DRAIN: begin
          if (mem_freeze) begin
            mem_wb_bubble = 1'b1;
          end else begin
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            drain_cnt_d  = drain_cnt_q - DC_W'(1);
            // Last non-frozen drain cycle: counter hits zero on this edge.
            if (drain_cnt_q <= DC_W'(1)) begin
              drain_cnt_d = '0;
              state_d     = S_HALTED;
            end
          end
        end
        S_HALTED: is_halted = 1'b1;
        default:  state_d   = S_RUN;
      endcase
    end
  end

  assign stall_inc = !reset && (state_q != S_HALTED) && !pc_write;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central sequencer for the 5-stage pipeline's stage-register enables and flushes. It merges three inputs into one consistent set of PC and stage-register write, flush and bubble controls:
- the load-use stall request from hazard detection
- the EX-stage branch/jump mispredict
- the data-memory ready handshake

It also runs the ECALL-halt drain: it stops fetch, lets the halting instruction and older instructions retire, then asserts is_halted. It keeps stall and flush performance counters.

Parameters:
DRAIN_CYCLES, 3, number of non-frozen cycles spent in DRAIN before HALTED (covers ID to WB of the ECALL)
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
hz_stall  input  1  load-use stall request for the instruction in ID
ex_mispredict  input  1  EX-stage branch/jump resolved against prediction; redirect PC this cycle
id_halt_req  input  1  instruction in ID is a halting ECALL (forwarded x17 == 10)
mem_req  input  1  MEM stage holds a load or store
mem_ready  input  1  data memory completes the access this cycle
pc_write  output  1  PC register enable
if_id_write  output  1  IF/ID enable
if_id_flush  output  1  IF/ID load NOP
id_ex_write  output  1  ID/EX enable
id_ex_bubble  output  1  ID/EX load control-zero bubble
ex_mem_write  output  1  EX/MEM enable
mem_wb_bubble  output  1  MEM/WB load bubble
is_halted  output  1  pipeline drained after halt
stall_count  output  CNT_W  cycles with pc_write == 0 in RUN or DRAIN
flush_count  output  CNT_W  accepted mispredicts

Behaviour:
Clock and reset
- One clock, clk. Reset is synchronous and active-high on reset.
- While reset is high: all write/flush/bubble outputs are 0 and is_halted is 0.
- On the edge with reset high: state = RUN, drain counter = 0, both counters = 0.
- Reset mid-DRAIN or in HALTED returns to RUN on the next edge.

Outputs and timing
- Control outputs are combinational from state and inputs, with zero latency.
- Counters and state are registered.

Freeze condition: mem_freeze = mem_req && !mem_ready. Valid in RUN and DRAIN.
- Output set: pc_write = 0, if_id_write = 0, id_ex_write = 0, ex_mem_write = 0, mem_wb_bubble = 1, all flushes = 0.
- mem_freeze has the highest priority. ex_mispredict and id_halt_req are ignored that cycle; the requester holds them.

State RUN, priority after mem_freeze:
1. ex_mispredict: pc_write = 1, if_id_flush = 1, id_ex_bubble = 1, id_ex_write = 1, ex_mem_write = 1. flush_count++.
   - hz_stall and id_halt_req are ignored that cycle because the ID instruction is wrong-path.
2. hz_stall: pc_write = 0, if_id_write = 0, id_ex_bubble = 1, id_ex_write = 1, ex_mem_write = 1.
   - id_halt_req is ignored until the stall clears.
3. id_halt_req: pc_write = 0 and if_id_write = 1; everything else advances normally.
   - Transition to DRAIN with drain counter = DRAIN_CYCLES.
4. Otherwise: all write enables = 1, flush/bubble = 0.

State DRAIN:
- Outputs: pc_write = 0, if_id_flush = 1, all other enables = 1.
- Drain counter decrements each non-frozen cycle; a frozen cycle holds it.
- ex_mispredict is ignored; only a non-branch ECALL or older retired instructions can be ahead.
- Counter reaching 0 → HALTED on the next edge.

State HALTED:
- is_halted = 1, all enables = 0, all flush/bubble = 0.
- No exit except reset.

Counters
- stall_count increments each cycle pc_write == 0 in RUN/DRAIN, including frozen cycles.
- flush_count increments as listed under RUN priority 1.
- Both saturate at all-ones.

Simultaneous events and boundary conditions
- mem_freeze with ex_mispredict → freeze only, no flush_count increment.
- ex_mispredict with id_halt_req → no DRAIN entry.
- mem_ready asserted on the same cycle as mem_req → no freeze.

Test Plan:
- Reset held 2 cycles, then idle inputs → all enables 1, is_halted 0, both counters 0.
- hz_stall = 1 for 1 cycle → that cycle pc_write = 0, if_id_write = 0, id_ex_bubble = 1; stall_count = 1; next cycle all enables 1.
- ex_mispredict and hz_stall together → pc_write = 1, if_id_flush = 1, id_ex_bubble = 1; flush_count = 1, stall_count = 0.
- mem_req = 1, mem_ready = 0 for 4 cycles while ex_mispredict = 1, then mem_ready = 1 → 4 frozen cycles (mem_wb_bubble = 1, enables 0), flush_count still 0; the mispredict is accepted on the ready cycle.
- id_halt_req pulse with DRAIN_CYCLES = 3 and one freeze cycle inside DRAIN → is_halted rises 5 cycles after the request edge and stays 1; pc_write = 0 throughout.
- id_halt_req with ex_mispredict in the same cycle → stays in RUN, is_halted never set; reset during HALTED → is_halted 0 on the next cycle.
